// File: rtl/neural_pkg.sv
// Shared definitions for the event fifo reader: state encoding, field widths
// and helpers to split an event entry into its {data, lt} fields.
package neural_pkg;

  localparam int EVT_DATA_W  = 16;
  localparam int EVT_LT_W    = 16;
  localparam int EVT_ENTRY_W = EVT_DATA_W + EVT_LT_W;

  // Field positions inside an entry: data sits above the delay field.
  localparam int EVT_LT_LSB   = 0;
  localparam int EVT_DATA_LSB = EVT_LT_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } reader_state_t;

  function automatic logic [EVT_DATA_W-1:0] evt_data(input logic [EVT_ENTRY_W-1:0] entry);
    return entry[EVT_ENTRY_W-1:EVT_DATA_LSB];
  endfunction

  function automatic logic [EVT_LT_W-1:0] evt_lt(input logic [EVT_ENTRY_W-1:0] entry);
    return entry[EVT_LT_W-1:EVT_LT_LSB];
  endfunction

endpackage

// File: rtl/fifo_event_reader_if.sv
// Bundle of the reader's fifo-side and downstream handshake signals.
// master: the reader itself; slave: the environment (fifo + consumer).
interface fifo_event_reader_if
  import neural_pkg::*;
#(
  parameter int ENTRY_WIDTH = EVT_ENTRY_W,
  parameter int DATA_WIDTH  = EVT_DATA_W
);
  logic                   fifo_empty;
  logic [ENTRY_WIDTH-1:0] fifo_data;
  logic                   fifo_dequeue;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_dequeue, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_dequeue, out_valid, out_data
  );
endinterface

// File: rtl/lt_countdown.sv
// Load/decrement delay counter. Load wins over decrement; the count holds at
// zero rather than wrapping.
module lt_countdown #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] r_count;

  // counter register: reset, load, or saturating decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count  = r_count;
  assign is_one = (r_count == WIDTH'(1));

endmodule

// File: rtl/fifo_event_reader.sv
// Event fifo reader: pops {data, lt} entries, waits lt cycles, then offers data
// downstream on a valid/ready handshake. Accepting an event while the fifo has
// another entry pops it at the same edge, so lt=0 traffic streams at 1/cycle.
// Optional feature macro: FIFO_EVENT_COUNT_EN adds the event_count port, a
// saturating count of accepted handshakes.
module fifo_event_reader
  import neural_pkg::*;
#(
  parameter int ENTRY_WIDTH = EVT_ENTRY_W,
  parameter int DATA_WIDTH  = EVT_DATA_W,
  parameter int LT_WIDTH    = EVT_LT_W
) (
  input  logic                clk,
  input  logic                reset,
  fifo_event_reader_if.master bus,
  output logic                busy
`ifdef FIFO_EVENT_COUNT_EN
  ,
  output logic [15:0]         event_count
`endif
);

  reader_state_t         r_state;
  reader_state_t         w_state_next;
  logic [DATA_WIDTH-1:0] r_data;

  logic [DATA_WIDTH-1:0] w_in_data;
  logic [LT_WIDTH-1:0]   w_in_lt;
  logic                  w_lt_zero;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_dec;
  logic [LT_WIDTH-1:0]   w_count;
  logic                  w_is_one;

  // Head entry fields; only meaningful at a pop edge.
  assign w_in_data = bus.fifo_data[ENTRY_WIDTH-1:LT_WIDTH];
  assign w_in_lt   = bus.fifo_data[LT_WIDTH-1:0];
  assign w_lt_zero = (w_in_lt == '0);

  // Pop whenever the reader is free or the presented event is leaving now.
  assign w_accept = (r_state == ST_PRESENT) && bus.out_ready;
  assign w_pop    = !reset && !bus.fifo_empty && ((r_state == ST_IDLE) || w_accept);

  lt_countdown #(
    .WIDTH (LT_WIDTH)
  ) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_in_lt),
    .dec      (w_dec),
    .count    (w_count),
    .is_one   (w_is_one)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = w_lt_zero ? ST_PRESENT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Zero count cannot occur in WAIT; treat it as expired rather than hang.
        if (w_is_one || (w_count == '0)) begin
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (w_accept) begin
          if (w_pop) begin
            w_state_next = w_lt_zero ? ST_PRESENT : ST_WAIT;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // outputs decoded from state and the pop decision
  always_comb begin
    bus.out_valid    = (r_state == ST_PRESENT);
    bus.fifo_dequeue = w_pop;
    busy             = (r_state != ST_IDLE);
    w_load           = w_pop;
    w_dec            = (r_state == ST_WAIT);
  end

  // payload register, captured at every pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_pop) begin
      r_data <= w_in_data;
    end
  end

  assign bus.out_data = r_data;

`ifdef FIFO_EVENT_COUNT_EN
  logic [15:0] r_event_count;

  // count accepted handshakes, holding at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_event_count <= '0;
    end else if (w_accept && (r_event_count != 16'hFFFF)) begin
      r_event_count <= r_event_count + 16'd1;
    end
  end

  assign event_count = r_event_count;
`endif

endmodule

// File: tb/tb_fifo_event_reader.sv
// Self-checking bench for fifo_event_reader. The bench owns a queue acting as
// the event fifo and a reference model that tracks the single held event as
// {data, cycle at which it becomes deliverable}.
module tb_fifo_event_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_event_reader_if #(.ENTRY_WIDTH(32), .DATA_WIDTH(16)) bus ();
  logic busy;
`ifdef FIFO_EVENT_COUNT_EN
  logic [15:0] event_count;
`endif

  fifo_event_reader #(
    .ENTRY_WIDTH (32),
    .DATA_WIDTH  (16),
    .LT_WIDTH    (16)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus),
    .busy  (busy)
`ifdef FIFO_EVENT_COUNT_EN
    ,
    .event_count (event_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // environment + reference model state
  logic [31:0] fq[$];
  bit          m_pend     = 0;
  logic [15:0] m_pdata    = '0;
  int          m_ready_at = 0;
  int          cyc        = 0;
  int          m_cnt      = 0;
  logic [15:0] mexp[$];
  logic [15:0] got[$];
  int          deq_pulses = 0;

  function automatic logic [31:0] mk(input int d, input int l);
    logic [15:0] dd;
    logic [15:0] ll;
    dd = 16'(d);
    ll = 16'(l);
    return {dd, ll};
  endfunction

  function automatic bit m_valid();
    return m_pend && (cyc >= m_ready_at);
  endfunction

  function automatic bit m_deq();
    return !rst && (fq.size() != 0) && (!m_pend || (m_valid() && (bus.out_ready == 1'b1)));
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : 32'($urandom());
  endtask

  // Advance one clock edge, updating fifo contents and the model.
  task automatic tick();
    bit          deq_n;
    bit          acc_n;
    logic [31:0] e;
    deq_n = m_deq();
    acc_n = m_valid() && (bus.out_ready == 1'b1);
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got.push_back(bus.out_data);
      $display("event delivered data=%0d cycle=%0d", bus.out_data, cyc);
    end
    if (bus.fifo_dequeue === 1'b1) deq_pulses++;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pend = 0;
      m_cnt  = 0;
    end else begin
      if (acc_n) begin
        mexp.push_back(m_pdata);
        m_pend = 0;
        if (m_cnt < 65535) m_cnt++;
      end
      if (deq_n) begin
        e          = fq.pop_front();
        m_pend     = 1;
        m_pdata    = e[31:16];
        m_ready_at = cyc + int'(e[15:0]);
      end
    end
    #1;
    drive_fifo();
  endtask

  task automatic clear_logs();
    got.delete();
    mexp.delete();
    deq_pulses = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    fq.push_back(mk(3, 0));
    drive_fifo();
    #1;
    checks++;
    if (bus.fifo_dequeue !== 1'b0) begin
      failures++;
      $display("FAIL reset_deq_pre got=%b want=0", bus.fifo_dequeue);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue, bus.out_data} !== {3'b000, 16'd0}) begin
        failures++;
        $display("FAIL reset_hold i=%0d valid/busy/deq/data got=%b/%b/%b/%0d want=0/0/0/0",
                 i, bus.out_valid, busy, bus.fifo_dequeue, bus.out_data);
      end
`ifdef FIFO_EVENT_COUNT_EN
      checks++;
      if (event_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_count got=%0d want=0", event_count);
      end
`endif
    end
    fq.delete();
    rst = 1'b0;
    drive_fifo();
    tick();
  endtask

  task automatic test_single();
    clear_logs();
    fq.push_back(mk(10, 1));
    drive_fifo();
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue} !== {m_valid(), m_pend, m_deq()}) begin
        failures++;
        $display("FAIL single_ctrl cyc=%0d valid/busy/deq got=%b want=%b", cyc,
                 {bus.out_valid, busy, bus.fifo_dequeue}, {m_valid(), m_pend, m_deq()});
      end
      if (m_valid()) begin
        checks++;
        if (bus.out_data !== m_pdata) begin
          failures++;
          $display("FAIL single_data cyc=%0d got=%0d want=%0d", cyc, bus.out_data, m_pdata);
        end
      end
      tick();
    end
    checks++;
    if (got.size() != 1 || got[0] !== 16'd10 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_result delivered=%0d busy=%b want delivered=1 (10) busy=0",
               got.size(), busy);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] want[3];
    want = '{16'd10, 16'd11, 16'd12};
    clear_logs();
    fq.push_back(mk(10, 1));
    fq.push_back(mk(11, 4));
    fq.push_back(mk(12, 2));
    drive_fifo();
    for (int i = 0; i < 16; i++) begin
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue} !== {m_valid(), m_pend, m_deq()}) begin
        failures++;
        $display("FAIL seq_ctrl cyc=%0d valid/busy/deq got=%b want=%b", cyc,
                 {bus.out_valid, busy, bus.fifo_dequeue}, {m_valid(), m_pend, m_deq()});
      end
      if (m_valid()) begin
        checks++;
        if (bus.out_data !== m_pdata) begin
          failures++;
          $display("FAIL seq_data cyc=%0d got=%0d want=%0d", cyc, bus.out_data, m_pdata);
        end
      end
      tick();
    end
    checks++;
    if (got.size() != 3 || deq_pulses != 3) begin
      failures++;
      $display("FAIL seq_counts delivered=%0d pops=%0d want delivered=3 pops=3",
               got.size(), deq_pulses);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++;
          $display("FAIL seq_order idx=%0d got=%0d want=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int run;
    int max_run;
    run = 0;
    max_run = 0;
    clear_logs();
    fq.push_back(mk(7, 0));
    fq.push_back(mk(8, 0));
    drive_fifo();
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue} !== {m_valid(), m_pend, m_deq()}) begin
        failures++;
        $display("FAIL b2b_ctrl cyc=%0d valid/busy/deq got=%b want=%b", cyc,
                 {bus.out_valid, busy, bus.fifo_dequeue}, {m_valid(), m_pend, m_deq()});
      end
      if (m_valid()) begin
        checks++;
        if (bus.out_data !== m_pdata) begin
          failures++;
          $display("FAIL b2b_data cyc=%0d got=%0d want=%0d", cyc, bus.out_data, m_pdata);
        end
      end
      if (bus.out_valid === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      tick();
    end
    checks++;
    if (max_run != 2 || got.size() != 2) begin
      failures++;
      $display("FAIL b2b_stream valid_run=%0d delivered=%0d want valid_run=2 delivered=2",
               max_run, got.size());
    end else begin
      checks++;
      if (got[0] !== 16'd7 || got[1] !== 16'd8) begin
        failures++;
        $display("FAIL b2b_order got=%0d,%0d want=7,8", got[0], got[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    fq.push_back(mk(5, 0));
    drive_fifo();
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = (i >= 6);
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue} !== {m_valid(), m_pend, m_deq()}) begin
        failures++;
        $display("FAIL bp_ctrl cyc=%0d valid/busy/deq got=%b want=%b", cyc,
                 {bus.out_valid, busy, bus.fifo_dequeue}, {m_valid(), m_pend, m_deq()});
      end
      if (m_valid()) begin
        checks++;
        if (bus.out_data !== m_pdata) begin
          failures++;
          $display("FAIL bp_data cyc=%0d got=%0d want=%0d", cyc, bus.out_data, m_pdata);
        end
      end
      tick();
    end
    checks++;
    if (got.size() != 1 || deq_pulses != 1) begin
      failures++;
      $display("FAIL bp_result delivered=%0d pops=%0d want delivered=1 pops=1",
               got.size(), deq_pulses);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    fq.push_back(mk(9, 3));
    drive_fifo();
    for (int i = 0; i < 9; i++) begin
      bus.out_ready = 1'b1;
      rst = (i == 2);
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue} !== {m_valid(), m_pend, m_deq()}) begin
        failures++;
        $display("FAIL rstmid_ctrl cyc=%0d valid/busy/deq got=%b want=%b", cyc,
                 {bus.out_valid, busy, bus.fifo_dequeue}, {m_valid(), m_pend, m_deq()});
      end
      tick();
    end
    rst = 1'b0;
    checks++;
    if (got.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_result delivered=%0d busy=%b want delivered=0 busy=0",
               got.size(), busy);
    end
`ifdef FIFO_EVENT_COUNT_EN
    checks++;
    if (event_count !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_count got=%0d want=0", event_count);
    end
`endif
  endtask

  task automatic test_random();
    int lt;
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      if (i < 360 && fq.size() < 4 && $urandom_range(0, 99) < 50) begin
        lt = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 12));
        fq.push_back(mk(int'($urandom_range(0, 65535)), lt));
        drive_fifo();
      end
      bus.out_ready = (i >= 360) || ($urandom_range(0, 99) < 70);
      #1;
      checks++;
      if ({bus.out_valid, busy, bus.fifo_dequeue} !== {m_valid(), m_pend, m_deq()}) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d valid/busy/deq got=%b want=%b", cyc,
                 {bus.out_valid, busy, bus.fifo_dequeue}, {m_valid(), m_pend, m_deq()});
      end
      if (m_valid()) begin
        checks++;
        if (bus.out_data !== m_pdata) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got=%0d want=%0d", cyc, bus.out_data, m_pdata);
        end
      end
`ifdef FIFO_EVENT_COUNT_EN
      checks++;
      if (event_count !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rand_count cyc=%0d got=%0d want=%0d", cyc, event_count, m_cnt);
      end
`endif
      tick();
    end
    checks++;
    if (got.size() != mexp.size() || got.size() == 0) begin
      failures++;
      $display("FAIL rand_total delivered=%0d want=%0d", got.size(), mexp.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== mexp[i]) begin
          failures++;
          $display("FAIL rand_order idx=%0d got=%0d want=%0d", i, got[i], mexp[i]);
        end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.out_ready  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    test_reset();
    test_single();
    test_sequence();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
